// File: rtl/lc3_pkg.sv
// Shared LC3 definitions: memory-access FSM states, writeback source select
// encodings and default bus widths.
package lc3_pkg;

    localparam int unsigned LC3_AW = 16;
    localparam int unsigned LC3_DW = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        IND  = 2'd1,
        RD   = 2'd2,
        WR   = 2'd3
    } mem_state_t;

    // Writeback source select; W_MEM picks memout from the memory-access stage.
    typedef enum logic [1:0] {
        W_ALU = 2'h0,
        W_MEM = 2'h1,
        W_PC  = 2'h2
    } wctl_t;

endpackage

// File: rtl/memaccess_if.sv
// Data-memory port between the LC3 memory-access stage (master) and the
// data memory (slave). Data_rdy may answer Data_req in the same cycle.
interface memaccess_if #(
    parameter int unsigned AW = 16,
    parameter int unsigned DW = 16
);

    logic [AW-1:0] Data_addr;
    logic [DW-1:0] Data_din;
    logic          Data_req;
    logic          Data_we;
    logic [DW-1:0] Data_dout;
    logic          Data_rdy;

    modport master (
        output Data_addr,
        output Data_din,
        output Data_req,
        output Data_we,
        input  Data_dout,
        input  Data_rdy
    );

    modport slave (
        input  Data_addr,
        input  Data_din,
        input  Data_req,
        input  Data_we,
        output Data_dout,
        output Data_rdy
    );

endinterface

// File: rtl/memaccess.sv
// LC3 memory-access stage: LD/LDR/LDI/ST/STR/STI against the data memory port.
// Indirect ops read a pointer first; every output is driven straight from a flop.
module memaccess
    import lc3_pkg::*;
#(
    parameter int unsigned AW = LC3_AW,
    parameter int unsigned DW = LC3_DW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          is_store,
    input  logic          indirect,
    input  logic [AW-1:0] M_Addr,
    input  logic [DW-1:0] M_Data,
    memaccess_if.master   dbus,
    output logic [DW-1:0] memout,
    output logic          busy,
    output logic          done
);

    mem_state_t    state_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] din_q;
    logic          store_q;
    logic [DW-1:0] memout_q;
    logic          req_q;
    logic          we_q;
    logic          busy_q;
    logic          done_q;
    logic          beat;

    assign beat = req_q & dbus.Data_rdy;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            din_q    <= '0;
            store_q  <= 1'b0;
            memout_q <= '0;
            req_q    <= 1'b0;
            we_q     <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        addr_q  <= M_Addr;
                        din_q   <= M_Data;
                        store_q <= is_store;
                        req_q   <= 1'b1;
                        busy_q  <= 1'b1;
                        if (indirect) begin
                            state_q <= IND;
                            we_q    <= 1'b0;
                        end else if (is_store) begin
                            state_q <= WR;
                            we_q    <= 1'b1;
                        end else begin
                            state_q <= RD;
                            we_q    <= 1'b0;
                        end
                    end
                end
                IND: begin
                    // Pointer word becomes the effective address; request stays up.
                    if (beat) begin
                        addr_q  <= AW'(dbus.Data_dout);
                        state_q <= store_q ? WR : RD;
                        we_q    <= store_q;
                    end
                end
                RD: begin
                    if (beat) begin
                        memout_q <= dbus.Data_dout;
                        done_q   <= 1'b1;
                        req_q    <= 1'b0;
                        busy_q   <= 1'b0;
                        state_q  <= IDLE;
                    end
                end
                WR: begin
                    if (beat) begin
                        done_q  <= 1'b1;
                        req_q   <= 1'b0;
                        we_q    <= 1'b0;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign dbus.Data_addr = addr_q;
    assign dbus.Data_din  = din_q;
    assign dbus.Data_req  = req_q;
    assign dbus.Data_we   = we_q;
    assign memout         = memout_q;
    assign busy           = busy_q;
    assign done           = done_q;

endmodule

// File: tb/tb_memaccess.sv
// Scoreboard bench for memaccess: a wait-state memory model answers requests,
// expected beats and load results are queued at issue and checked on output.
module tb_memaccess;
    import lc3_pkg::*;

    typedef struct {
        logic [15:0] addr;
        logic        we;
        logic [15:0] din;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        is_store = 1'b0;
    logic        indirect = 1'b0;
    logic [15:0] M_Addr = '0;
    logic [15:0] M_Data = '0;
    logic [15:0] memout;
    logic        busy;
    logic        done;

    memaccess_if #(.AW(16), .DW(16)) bus ();

    memaccess #(.AW(16), .DW(16)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .is_store (is_store),
        .indirect (indirect),
        .M_Addr   (M_Addr),
        .M_Data   (M_Data),
        .dbus     (bus.master),
        .memout   (memout),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    logic [15:0] mem [0:65535];
    int unsigned waits = 0;
    int unsigned wcnt;
    beat_t       exp_q[$];
    logic [15:0] res_q[$];
    logic [15:0] last_load = '0;
    int          total = 0;
    int          bad = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // Memory model: answers after 'waits' stalled cycles per beat.
    always_comb begin
        bus.Data_rdy  = bus.Data_req && (wcnt >= waits);
        bus.Data_dout = mem[bus.Data_addr];
    end

    always @(posedge clk or negedge rst) begin
        if (!rst) wcnt <= 0;
        else if (bus.Data_req) wcnt <= bus.Data_rdy ? 0 : wcnt + 1;
    end

    always @(negedge clk) begin
        if (rst) begin
            if (bus.Data_req) begin
                if (exp_q.size() == 0) begin
                    check_eq("stray_req", 1, 0);
                end else begin
                    check_eq("addr", bus.Data_addr, exp_q[0].addr);
                    check_eq("we", bus.Data_we, exp_q[0].we);
                    if (exp_q[0].we) check_eq("din", bus.Data_din, exp_q[0].din);
                    if (bus.Data_rdy) void'(exp_q.pop_front());
                end
            end
            if (done) begin
                if (res_q.size() == 0) check_eq("stray_done", 1, 0);
                else check_eq("memout", memout, res_q.pop_front());
            end
        end
    end

    task automatic run_op(input logic st, input logic ind, input logic [15:0] a,
                          input logic [15:0] d, input bit b2b, input bit poke,
                          output int lat);
        beat_t       bt;
        logic [15:0] tgt;
        if (!b2b) begin
            @(posedge clk);
            #1;
        end
        tgt = ind ? mem[a] : a;
        if (ind) begin
            bt.addr = a; bt.we = 1'b0; bt.din = '0;
            exp_q.push_back(bt);
        end
        bt.addr = tgt; bt.we = st; bt.din = d;
        exp_q.push_back(bt);
        if (!st) last_load = mem[tgt];
        res_q.push_back(last_load);
        start = 1'b1; is_store = st; indirect = ind; M_Addr = a; M_Data = d;
        @(posedge clk);
        #1;
        start = 1'b0; M_Addr = 16'hFFFF; M_Data = 16'hFFFF;
        check_eq("busy_acc", busy, 1);
        lat = 0;
        for (int n = 1; n <= 60; n++) begin
            if (poke && n == 1) begin
                start = 1'b1; is_store = 1'b1; indirect = 1'b0; M_Addr = 16'hDEAD;
            end
            @(posedge clk);
            #1;
            start = 1'b0;
            if (done) begin
                lat = n;
                break;
            end
            check_eq("busy_wait", busy, 1);
        end
    endtask

    initial begin
        int lat;
        beat_t bt;
        #3;
        check_eq("rst_req", bus.Data_req, 0);
        check_eq("rst_we", bus.Data_we, 0);
        check_eq("rst_addr", bus.Data_addr, 0);
        check_eq("rst_din", bus.Data_din, 0);
        check_eq("rst_memout", memout, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        @(negedge clk);
        rst = 1'b1;

        mem[16'h3000] = 16'hBEEF;
        run_op(1'b0, 1'b0, 16'h3000, 16'h0000, 1'b0, 1'b0, lat);
        check_eq("ld_lat", lat, 1);
        check_eq("ld_val", memout, 16'hBEEF);

        run_op(1'b1, 1'b0, 16'h4010, 16'h1234, 1'b0, 1'b0, lat);
        check_eq("st_lat", lat, 1);
        check_eq("st_memout", memout, 16'hBEEF);

        mem[16'h3000] = 16'h5000;
        mem[16'h5000] = 16'h00AA;
        run_op(1'b0, 1'b1, 16'h3000, 16'h0000, 1'b0, 1'b0, lat);
        check_eq("ldi_lat", lat, 2);
        check_eq("ldi_val", memout, 16'h00AA);

        waits = 3;
        mem[16'h3002] = 16'h6000;
        run_op(1'b1, 1'b1, 16'h3002, 16'h7777, 1'b0, 1'b0, lat);
        check_eq("sti_lat", lat, 8);
        check_eq("sti_memout", memout, 16'h00AA);

        mem[16'h3100] = 16'h4242;
        run_op(1'b0, 1'b0, 16'h3100, 16'h0000, 1'b0, 1'b1, lat);
        check_eq("poke_lat", lat, 4);
        check_eq("poke_val", memout, 16'h4242);
        run_op(1'b0, 1'b0, 16'h3000, 16'h0000, 1'b1, 1'b0, lat);
        check_eq("b2b_lat", lat, 4);
        check_eq("b2b_val", memout, 16'h5000);

        // Reset abandons a load stalled in RD.
        waits = 5;
        mem[16'h3200] = 16'h1111;
        @(posedge clk);
        #1;
        bt.addr = 16'h3200; bt.we = 1'b0; bt.din = '0;
        exp_q.push_back(bt);
        res_q.push_back(16'h1111);
        start = 1'b1; is_store = 1'b0; indirect = 1'b0; M_Addr = 16'h3200;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check_eq("mid_req", bus.Data_req, 0);
        check_eq("mid_addr", bus.Data_addr, 0);
        check_eq("mid_busy", busy, 0);
        check_eq("mid_done", done, 0);
        check_eq("mid_memout", memout, 0);
        exp_q.delete();
        res_q.delete();
        last_load = '0;
        @(negedge clk);
        rst = 1'b1;
        waits = 0;
        run_op(1'b0, 1'b0, 16'h3000, 16'h0000, 1'b0, 1'b0, lat);
        check_eq("post_lat", lat, 1);
        check_eq("post_val", memout, 16'h5000);

        repeat (2) @(posedge clk);
        #1;
        check_eq("q_empty", exp_q.size() + res_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

endmodule
